// File: rtl/l2_request_arbiter_pkg.sv
// ============================================================================
// Module : l2_request_arbiter_pkg
// Brief  : Shared L2 request types plus arbiter grant type and defaults.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package l2_request_arbiter_pkg;

    localparam int CACHE_LINE_BITS = 512;

    typedef logic [CACHE_LINE_BITS-1:0] cache_line_data_t;

    typedef enum logic [1:0] {
        L2REQ_LOAD        = 2'd0,
        L2REQ_STORE       = 2'd1,
        L2REQ_FLUSH       = 2'd2,
        L2REQ_DINVALIDATE = 2'd3
    } l2req_packet_type_t;

    typedef struct packed {
        l2req_packet_type_t packet_type;
        logic [7:0]         id;
        logic [31:0]        address;
    } l2req_packet_t;

    // Bit 0 is the restart port; bits [1 +: NUM_REQUESTERS] are the cores.
    localparam int L2_ARB_MAX_REQUESTERS = 16;
    typedef logic [L2_ARB_MAX_REQUESTERS:0] l2_arb_grant_t;

    localparam int unsigned L2_ARB_DEFAULT_STARVE_LIMIT = 8;

endpackage

`default_nettype wire

// File: rtl/l2_request_arbiter_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin one-hot arbiter; search starts at a rotating pointer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQUESTERS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      update_lru,
    output logic [NUM_REQUESTERS-1:0] grant_oh
);

    localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam logic [PTR_W:0]   c_num_ext = (PTR_W+1)'(NUM_REQUESTERS);
    localparam logic [PTR_W-1:0] c_last    = PTR_W'(NUM_REQUESTERS - 1);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_grant_idx;
    logic [PTR_W:0]   w_scan;
    logic             w_found;

    always_comb begin
        grant_oh    = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_scan      = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            // Index wraps modulo NUM_REQUESTERS, which need not be a power of 2.
            w_scan = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (w_scan >= c_num_ext) begin
                w_scan = w_scan - c_num_ext;
            end
            if (!w_found && request[w_scan[PTR_W-1:0]]) begin
                w_found                      = 1'b1;
                grant_oh[w_scan[PTR_W-1:0]]  = 1'b1;
                w_grant_idx                  = w_scan[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (update_lru && w_found) begin
            r_ptr <= (w_grant_idx == c_last) ? '0 : w_grant_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/l2_request_arbiter.sv
// ============================================================================
// Module : l2_request_arbiter
// Brief  : L2 front-end arbiter: restart port with starvation guard vs cores.
//          Optional perf pulses when L2_ARB_PERF_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int          NUM_REQUESTERS = 4,
    parameter int unsigned STARVE_LIMIT   = L2_ARB_DEFAULT_STARVE_LIMIT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] l2i_request_valid,
    input  l2req_packet_t             l2i_request [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0] l2_ready,
    input  logic                      restart_valid,
    input  l2req_packet_t             restart_request,
    input  cache_line_data_t          restart_data,
    input  logic                      restart_is_flush,
    output logic                      restart_ack,
    input  logic                      l2_stall,
`ifdef L2_ARB_PERF_EN
    output logic                      perf_restart_grant,
    output logic                      perf_core_grant,
`endif
    output logic                      l2a_request_valid,
    output l2req_packet_t             l2a_request,
    output cache_line_data_t          l2a_data_from_memory,
    output logic                      l2a_is_l2_fill,
    output logic                      l2a_is_restarted_flush
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1) > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_LIMIT);

    logic [NUM_REQUESTERS-1:0] w_rr_grant_oh;
    logic                      w_core_pending;
    logic                      w_restart_wins;
    logic                      w_grant_restart;
    logic                      w_grant_core;
    l2req_packet_t             w_core_pkt;
    l2_arb_grant_t             w_grant;

    logic [CNT_W-1:0]          r_starve_cnt;
    logic                      r_valid;
    l2req_packet_t             r_request;
    cache_line_data_t          r_data;
    logic                      r_is_fill;
    logic                      r_is_flush;

    assign w_core_pending  = |l2i_request_valid;
    assign w_restart_wins  = restart_valid && (!w_core_pending || (r_starve_cnt < c_starve_max));
    assign w_grant_restart = !reset && !l2_stall && w_restart_wins;
    assign w_grant_core    = !reset && !l2_stall && !w_restart_wins && w_core_pending;

    rr_arbiter #(
        .NUM_REQUESTERS (NUM_REQUESTERS)
    ) u_core_rr (
        .clk        (clk),
        .reset      (reset),
        .request    (l2i_request_valid),
        .update_lru (w_grant_core),
        .grant_oh   (w_rr_grant_oh)
    );

    assign l2_ready    = w_grant_core ? w_rr_grant_oh : '0;
    assign restart_ack = w_grant_restart;

    always_comb begin
        w_core_pkt = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (w_rr_grant_oh[i]) begin
                w_core_pkt = l2i_request[i];
            end
        end
    end

    always_comb begin
        w_grant                     = '0;
        w_grant[0]                  = restart_ack;
        w_grant[1 +: NUM_REQUESTERS] = l2_ready;
    end

    // Counter only advances while a core is actually waiting behind restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!l2_stall) begin
            if (w_grant_restart && w_core_pending) begin
                r_starve_cnt <= (r_starve_cnt == c_starve_max) ? r_starve_cnt
                                                               : r_starve_cnt + 1'b1;
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_request  <= '0;
            r_data     <= '0;
            r_is_fill  <= 1'b0;
            r_is_flush <= 1'b0;
        end else if (!l2_stall) begin
            r_valid <= w_grant_restart || w_grant_core;
            if (w_grant_restart) begin
                r_request  <= restart_request;
                r_data     <= restart_data;
                r_is_fill  <= !restart_is_flush;
                r_is_flush <= restart_is_flush;
            end else if (w_grant_core) begin
                r_request  <= w_core_pkt;
                r_is_fill  <= 1'b0;
                r_is_flush <= 1'b0;
            end
        end
    end

    assign l2a_request_valid      = r_valid;
    assign l2a_request            = r_request;
    assign l2a_data_from_memory   = r_data;
    assign l2a_is_l2_fill         = r_is_fill;
    assign l2a_is_restarted_flush = r_is_flush;

`ifdef L2_ARB_PERF_EN
    logic r_perf_restart;
    logic r_perf_core;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_restart <= 1'b0;
            r_perf_core    <= 1'b0;
        end else begin
            r_perf_restart <= w_grant_restart;
            r_perf_core    <= w_grant_core;
        end
    end

    assign perf_restart_grant = r_perf_restart;
    assign perf_core_grant    = r_perf_core;
`endif

    a_flush_type : assert property (@(posedge clk) disable iff (reset)
        (restart_valid && restart_is_flush) |-> (restart_request.packet_type == L2REQ_FLUSH));

    a_grant_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(w_grant));

endmodule

`default_nettype wire

// File: tb/tb_l2_request_arbiter.sv
// ============================================================================
// Module : tb_l2_request_arbiter
// Brief  : Directed self-checking bench for l2_request_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_l2_request_arbiter;
    import l2_request_arbiter_pkg::*;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     l2i_request_valid;
    l2req_packet_t    l2i_request [N];
    logic [N-1:0]     l2_ready;
    logic             restart_valid;
    l2req_packet_t    restart_request;
    cache_line_data_t restart_data;
    logic             restart_is_flush;
    logic             restart_ack;
    logic             l2_stall;
    logic             l2a_request_valid;
    l2req_packet_t    l2a_request;
    cache_line_data_t l2a_data_from_memory;
    logic             l2a_is_l2_fill;
    logic             l2a_is_restarted_flush;
`ifdef L2_ARB_PERF_EN
    logic             perf_restart_grant;
    logic             perf_core_grant;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    l2_request_arbiter #(
        .NUM_REQUESTERS (N),
        .STARVE_LIMIT   (8)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .l2i_request_valid      (l2i_request_valid),
        .l2i_request            (l2i_request),
        .l2_ready               (l2_ready),
        .restart_valid          (restart_valid),
        .restart_request        (restart_request),
        .restart_data           (restart_data),
        .restart_is_flush       (restart_is_flush),
        .restart_ack            (restart_ack),
        .l2_stall               (l2_stall),
`ifdef L2_ARB_PERF_EN
        .perf_restart_grant     (perf_restart_grant),
        .perf_core_grant        (perf_core_grant),
`endif
        .l2a_request_valid      (l2a_request_valid),
        .l2a_request            (l2a_request),
        .l2a_data_from_memory   (l2a_data_from_memory),
        .l2a_is_l2_fill         (l2a_is_l2_fill),
        .l2a_is_restarted_flush (l2a_is_restarted_flush)
    );

    task automatic check_value(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic l2req_packet_t make_pkt(l2req_packet_type_t t, logic [7:0] id);
        l2req_packet_t p;
        p.packet_type = t;
        p.id          = id;
        p.address     = {24'h00C0DE, id};
        return p;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cache_line_data_t d1;
        cache_line_data_t d2;
        int               n_ack;
        d1 = {16{32'hCAFE0001}};
        d2 = {16{32'h5A5A0002}};

        reset             = 1'b1;
        l2i_request_valid = '0;
        restart_valid     = 1'b0;
        restart_request   = '0;
        restart_data      = '0;
        restart_is_flush  = 1'b0;
        l2_stall          = 1'b0;
        for (int i = 0; i < N; i++) l2i_request[i] = make_pkt(L2REQ_LOAD, 8'(8'h10 + i));
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check_value("rst_valid", 512'(l2a_request_valid), 512'd0);
        check_value("rst_req",   512'(l2a_request), 512'd0);
        check_value("rst_data",  l2a_data_from_memory, 512'd0);
        check_value("rst_fill",  512'(l2a_is_l2_fill), 512'd0);
        check_value("rst_flush", 512'(l2a_is_restarted_flush), 512'd0);
        check_value("rst_ready", 512'(l2_ready), 512'd0);
        check_value("rst_ack",   512'(restart_ack), 512'd0);
        reset = 1'b0;

        // Round robin over all four cores, wrapping 3 -> 0
        l2i_request_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_value("rr_ready", 512'(l2_ready), 512'(4'b0001 << (k % 4)));
            step();
            check_value("rr_valid", 512'(l2a_request_valid), 512'd1);
            check_value("rr_id", 512'(l2a_request.id), 512'(8'h10 + (k % 4)));
        end
        l2i_request_valid = '0;
        step();
        check_value("idle_valid", 512'(l2a_request_valid), 512'd0);

        // Starvation guard: 8 restarts, then core 2, then restarts again
        restart_valid     = 1'b1;
        restart_request   = make_pkt(L2REQ_LOAD, 8'hA0);
        restart_data      = d1;
        l2i_request_valid = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_value("starve_ack", 512'(restart_ack), 512'd1);
            check_value("starve_noready", 512'(l2_ready), 512'd0);
            step();
        end
        #1;
        check_value("starve_core_ack", 512'(restart_ack), 512'd0);
        check_value("starve_core_ready", 512'(l2_ready), 512'(4'b0100));
        step();
        check_value("starve_core_id", 512'(l2a_request.id), 512'h12);
        n_ack = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (l2_ready[2]) break;
            if (restart_ack) n_ack++;
            step();
        end
        check_value("starve_rearm", 512'(n_ack), 512'd8);
        step();
        l2i_request_valid = '0;
        restart_valid     = 1'b0;
        step();

        // Restart flavours: flush then fill
        restart_valid    = 1'b1;
        restart_request  = make_pkt(L2REQ_FLUSH, 8'hB1);
        restart_is_flush = 1'b1;
        restart_data     = d1;
        #1;
        check_value("flush_ack", 512'(restart_ack), 512'd1);
        step();
        check_value("flush_flag", 512'(l2a_is_restarted_flush), 512'd1);
        check_value("flush_fill", 512'(l2a_is_l2_fill), 512'd0);
        check_value("flush_id", 512'(l2a_request.id), 512'hB1);
        restart_request  = make_pkt(L2REQ_LOAD, 8'hB2);
        restart_is_flush = 1'b0;
        restart_data     = d2;
        step();
        check_value("fill_flag", 512'(l2a_is_l2_fill), 512'd1);
        check_value("fill_flush", 512'(l2a_is_restarted_flush), 512'd0);
        check_value("fill_data", l2a_data_from_memory, d2);
        restart_valid     = 1'b0;
        l2i_request_valid = 4'b0010;
        step();
        check_value("core_fill", 512'(l2a_is_l2_fill), 512'd0);
        check_value("core_id", 512'(l2a_request.id), 512'h11);

        // Stall with everything valid; pointer now at 2
        l2i_request_valid = 4'b1111;
        restart_valid     = 1'b1;
        l2_stall          = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_value("stall_ready", 512'(l2_ready), 512'd0);
            check_value("stall_ack", 512'(restart_ack), 512'd0);
            step();
            check_value("stall_hold_id", 512'(l2a_request.id), 512'h11);
            check_value("stall_hold_valid", 512'(l2a_request_valid), 512'd1);
        end
        restart_valid = 1'b0;
        l2_stall      = 1'b0;
        #1;
        check_value("stall_resume", 512'(l2_ready), 512'(4'b0100));
        step();
        check_value("resume_valid", 512'(l2a_request_valid), 512'd1);

        // Asynchronous reset mid-operation
        reset = 1'b1;
        #1;
        check_value("arst_valid", 512'(l2a_request_valid), 512'd0);
        check_value("arst_ready", 512'(l2_ready), 512'd0);
        step();
        reset = 1'b0;
        #1;
        check_value("arst_first", 512'(l2_ready), 512'(4'b0001));
        l2i_request_valid = '0;
        step();

`ifdef L2_ARB_PERF_EN
        restart_valid   = 1'b1;
        restart_request = make_pkt(L2REQ_LOAD, 8'hC0);
        step();
        check_value("perf_r1", 512'({perf_restart_grant, perf_core_grant}), 512'(2'b10));
        step();
        check_value("perf_r2", 512'({perf_restart_grant, perf_core_grant}), 512'(2'b10));
        restart_valid     = 1'b0;
        l2i_request_valid = 4'b0001;
        step();
        check_value("perf_c1", 512'({perf_restart_grant, perf_core_grant}), 512'(2'b01));
        l2i_request_valid = '0;
        step();
        check_value("perf_idle", 512'({perf_restart_grant, perf_core_grant}), 512'(2'b00));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire
